// File: rtl/cpu_uart_pkg.sv
// cpu_uart_pkg: shared constants and receiver FSM encoding for the CPU UART
package cpu_uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int DEFAULT_BAUD_PERIOD = 104;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/cpu_uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO drained by the peripheral bus
module uart_rx_fifo
    import cpu_uart_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      empty,
    output logic                      full,
    output logic [AW:0]               count
);
    logic [UART_DATA_BITS-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    // a pop needs data; a push into a full FIFO lands only when a pop frees a slot this cycle
    always_comb begin
        empty = count == '0;
        full = count[AW];
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata = empty ? '0 : mem[rd_ptr];
    end
    // pointers wrap modulo depth; occupancy tracks accepted pushes and pops
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset because reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cpu_uart_rx.sv
// cpu_uart_rx: 8N1 UART receiver with FWFT byte FIFO and sticky error flags
module cpu_uart_rx
    import cpu_uart_pkg::*;
#(
    parameter int BAUD_PERIOD = DEFAULT_BAUD_PERIOD,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic                      RXD,
    input  logic                      rd_en,
    input  logic                      clear_errors,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      rx_valid,
    output logic [FIFO_DEPTH_LOG2:0]  fifo_count,
    output logic                      framing_error,
    output logic                      overrun,
    output logic                      rx_busy
);
    localparam int CW = $clog2(BAUD_PERIOD);
    localparam logic [CW-1:0] HALF = CW'(BAUD_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_PERIOD - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
    rx_state_t state, state_n;
    logic rxd_m, rxd_s, rxd_p;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [UART_DATA_BITS-1:0] sh, sh_n;
    logic push, ferr, full, empty, fall, expired, ov_set;
    assign fall = rxd_p && !rxd_s;
    assign expired = cnt == '0;
    assign rx_valid = !empty;
    assign rx_busy = state != IDLE;
    assign ov_set = push && full && !(rd_en && rx_valid);
    // two-flop synchronizer plus previous sample; idle-high reset prevents a false start edge
    always_ff @(posedge clk) begin
        if (sync_reset) {rxd_m, rxd_s, rxd_p} <= 3'b111;
        else {rxd_m, rxd_s, rxd_p} <= {RXD, rxd_m, rxd_s};
    end
    // state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
        end
    end
    // frame sequencing: half-bit to start midpoint, then one full bit per data and stop sample
    always_comb begin
        state_n = state;
        cnt_n = cnt - 1'b1;
        idx_n = idx;
        sh_n = sh;
        push = 1'b0;
        ferr = 1'b0;
        case (state)
            IDLE: if (fall) begin
                cnt_n = HALF;
                state_n = START;
            end
            START: if (expired) begin
                cnt_n = FULL;
                idx_n = '0;
                state_n = rxd_s ? IDLE : DATA;
            end
            DATA: if (expired) begin
                sh_n = {rxd_s, sh[UART_DATA_BITS-1:1]};
                cnt_n = FULL;
                idx_n = idx + 1'b1;
                state_n = idx == LAST_BIT ? STOP : DATA;
            end
            STOP: if (expired) begin
                push = rxd_s;
                ferr = !rxd_s;
                state_n = rxd_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: state_n = rxd_s ? IDLE : WAIT_HIGH;
            default: state_n = IDLE;
        endcase
    end
    // sticky errors; a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            framing_error <= 1'b0;
            overrun <= 1'b0;
        end else begin
            framing_error <= ferr || (framing_error && !clear_errors);
            overrun <= ov_set || (overrun && !clear_errors);
        end
    end
    uart_rx_fifo #(.AW(FIFO_DEPTH_LOG2)) u_fifo (
        .clk(clk),
        .sync_reset(sync_reset),
        .push(push),
        .wdata(sh),
        .pop(rd_en),
        .rdata(rd_data),
        .empty(empty),
        .full(full),
        .count(fifo_count)
    );
endmodule

// File: tb/tb_cpu_uart_rx.sv
// tb_cpu_uart_rx: randomized and directed frames checked against a queue-based receiver model
module tb_cpu_uart_rx;
    localparam int B = 16;
    localparam int DEPTH = 4;
    localparam int STOP_AT = 3 + B / 2 + 9 * B;
    logic clk = 0, sync_reset = 1, RXD = 1, rd_en = 0, clear_errors = 0;
    logic [7:0] rd_data;
    logic rx_valid, framing_error, overrun, rx_busy;
    logic [2:0] fifo_count;
    typedef struct {int c; logic [7:0] d; bit ok;} ev_t;
    ev_t ev[$];
    logic [7:0] mq[$];
    bit m_fe, m_ov, chk_on, busy_known = 1, m_pop, m_psh, m_ok;
    logic [7:0] m_d;
    int cyc, n_chk, n_pass, rd_prob;
    int pop_at = -1, blo = 1, bhi = 0, plo = 1, phi = 0;

    cpu_uart_rx #(.BAUD_PERIOD(B), .FIFO_DEPTH_LOG2(2)) dut (
        .clk(clk), .sync_reset(sync_reset), .RXD(RXD), .rd_en(rd_en),
        .clear_errors(clear_errors), .rd_data(rd_data), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .framing_error(framing_error),
        .overrun(overrun), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    endtask

    // model: FIFO as a queue, frame completions as scheduled events, errors as sticky bits
    always @(posedge clk) begin
        cyc++;
        if (sync_reset) begin
            mq.delete();
            ev.delete();
            m_fe = 0;
            m_ov = 0;
            blo = 1; bhi = 0; plo = 1; phi = 0;
        end else begin
            m_pop = rd_en && mq.size() > 0;
            m_psh = 0;
            if (ev.size() > 0 && ev[0].c == cyc) begin
                m_psh = 1;
                m_d = ev[0].d;
                m_ok = ev[0].ok;
                void'(ev.pop_front());
            end
            if (clear_errors) begin
                m_fe = 0;
                m_ov = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_psh && !m_ok) m_fe = 1;
            else if (m_psh) begin
                if (mq.size() < DEPTH) mq.push_back(m_d);
                else m_ov = 1;
            end
        end
    end

    // read strobe: scheduled single pops plus optional random pops
    always @(posedge clk) begin
        #1;
        rd_en = (cyc + 1 == pop_at) || ($urandom_range(99) < rd_prob);
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rx_valid", rx_valid, mq.size() > 0);
            chk("fifo_count", fifo_count, mq.size());
            if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
            chk("framing_error", framing_error, m_fe);
            chk("overrun", overrun, m_ov);
            if (busy_known)
                chk("rx_busy", rx_busy, (cyc >= blo && cyc <= bhi) || (cyc >= plo && cyc <= phi));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ok, input int st, input bit pop_on_stop);
        int c0;
        ev_t e;
        @(posedge clk);
        #1;
        c0 = cyc;
        RXD = 0;
        if (ok) begin
            plo = blo; phi = bhi;
            blo = c0 + 3; bhi = c0 + STOP_AT - 1;
        end else busy_known = 0;
        e.c = c0 + STOP_AT;
        e.d = d;
        e.ok = ok;
        ev.push_back(e);
        if (pop_on_stop) pop_at = c0 + STOP_AT;
        wait_cyc(B);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            wait_cyc(B);
        end
        RXD = ok;
        wait_cyc(st);
    endtask

    task automatic pop_one(input logic [7:0] exp);
        @(negedge clk);
        chk("pop_data", rd_data, exp);
        pop_at = cyc + 2;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear_errors = 1;
        @(posedge clk);
        #1 clear_errors = 0;
    endtask

    initial begin
        int c0;
        bit ok;
        repeat (3) @(posedge clk);
        #1 sync_reset = 0;
        chk_on = 1;
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_fe", framing_error, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_busy", rx_busy, 0);
        send_frame(8'hA5, 1, 16, 0);
        chk("single_count", fifo_count, 1);
        chk("single_valid", rx_valid, 1);
        chk("single_data", rd_data, 8'hA5);
        pop_one(8'hA5);
        chk("single_empty_count", fifo_count, 0);
        chk("single_empty_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        c0 = cyc;
        plo = blo; phi = bhi;
        blo = c0 + 3; bhi = c0 + 10;
        RXD = 0;
        wait_cyc(4);
        RXD = 1;
        wait_cyc(30);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_fe", framing_error, 0);
        send_frame(8'h3C, 0, 16, 0);
        wait_cyc(40);
        RXD = 1;
        wait_cyc(6);
        chk("frame_fe", framing_error, 1);
        chk("frame_count", fifo_count, 0);
        chk("frame_busy", rx_busy, 0);
        busy_known = 1;
        pulse_clear();
        @(negedge clk);
        chk("frame_fe_clear", framing_error, 0);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 16, 0);
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", overrun, 1);
        for (int i = 1; i <= 4; i++) pop_one(8'(i));
        send_frame(8'h06, 1, 16, 0);
        send_frame(8'h07, 1, 16, 0);
        pop_one(8'h06);
        pop_one(8'h07);
        pulse_clear();
        @(negedge clk);
        chk("ovr_clear", overrun, 0);
        for (int i = 8'h11; i <= 8'h14; i++) send_frame(8'(i), 1, 16, 0);
        send_frame(8'h15, 1, 16, 1);
        chk("sim_count", fifo_count, 4);
        chk("sim_ov", overrun, 0);
        for (int i = 8'h12; i <= 8'h15; i++) pop_one(8'(i));
        send_frame(8'h77, 1, 16, 0);
        @(posedge clk);
        #1;
        c0 = cyc;
        plo = blo; phi = bhi;
        blo = c0 + 3; bhi = c0 + 100000;
        RXD = 0;
        wait_cyc(4 * B);
        RXD = 1;
        wait_cyc(3);
        sync_reset = 1;
        wait_cyc(1);
        sync_reset = 0;
        @(negedge clk);
        chk("mid_valid", rx_valid, 0);
        chk("mid_count", fifo_count, 0);
        chk("mid_data", rd_data, 0);
        chk("mid_busy", rx_busy, 0);
        send_frame(8'h5A, 1, 16, 0);
        chk("mid_next_count", fifo_count, 1);
        pop_one(8'h5A);
        for (int k = 0; k < 40; k++) begin
            rd_prob = k < 20 ? 1 : 50;
            ok = $urandom_range(9) != 0;
            send_frame(8'($urandom), ok, ok ? $urandom_range(20, 8) : $urandom_range(20, 12), 0);
            if (!ok) begin
                wait_cyc($urandom_range(30, 1));
                RXD = 1;
                wait_cyc(6);
                busy_known = 1;
            end
            if ($urandom_range(3) == 0) pulse_clear();
            wait_cyc($urandom_range(10));
        end
        rd_prob = 0;
        wait_cyc(10);
        for (int i = 0; i < DEPTH && mq.size() > 0; i++) pop_one(mq[0]);
        chk("drain_count", fifo_count, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
